// File: rtl/buffer_arbiter_16.sv
// Round-robin burst arbiter sharing one registered 16-bit valid/ready output stage
// between the DLX core (port 0) and the sharpening engine (port 1).
module buffer_arbiter_16 #(
   parameter int unsigned DW = 16,
   parameter int unsigned LW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic [LW-1:0] len0,
   input  logic [DW-1:0] d0,
   input  logic          vld0,
   input  logic          req1,
   input  logic [LW-1:0] len1,
   input  logic [DW-1:0] d1,
   input  logic          vld1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] out_d,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BURST0 = 2'd1,
      S_BURST1 = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          ptr_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] count_q;
   logic          accept_c;
   logic          last_c;
   logic [DW-1:0] word_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state: grant on request (pointer breaks ties), leave on last word or request drop
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req0 && (!req1 || !ptr_q)) state_d = S_BURST0;
            else if (req1)                 state_d = S_BURST1;
         end
         S_BURST0: if (last_c || !req0) state_d = S_IDLE;
         S_BURST1: if (last_c || !req1) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Word acceptance from the granted port while the output register can take it
   always_comb begin
      accept_c = 1'b0;
      word_c   = d0;
      case (state_q)
         S_BURST0: accept_c = vld0 && (!out_vld || out_rdy);
         S_BURST1: begin
            accept_c = vld1 && (!out_vld || out_rdy);
            word_c   = d1;
         end
         default: accept_c = 1'b0;
      endcase
      last_c = accept_c && (count_q == len_q);
   end

   // Grant, status, burst length/count and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ptr_q   <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         gnt0 <= (state_d == S_BURST0);
         gnt1 <= (state_d == S_BURST1);
         busy <= (state_d != S_IDLE);
         done <= last_c;
         if (state_q == S_IDLE) begin
            count_q <= '0;
            if (state_d == S_BURST1)      len_q <= len1;
            else if (state_d == S_BURST0) len_q <= len0;
         end else begin
            if (accept_c) count_q <= count_q + LW'(1);
            if (state_d == S_IDLE) ptr_q <= (state_q == S_BURST0);
         end
      end
   end

   // Output register drains on its own, independent of the burst state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_d   <= '0;
         out_vld <= 1'b0;
      end else if (accept_c) begin
         out_d   <= word_c;
         out_vld <= 1'b1;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_buffer_arbiter_16.sv
// Self-checking bench for buffer_arbiter_16: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_buffer_arbiter_16;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, vld0, vld1, out_rdy;
   logic [3:0]  len0, len1;
   logic [15:0] d0, d1;
   logic        gnt0, gnt1, out_vld, busy, done;
   logic [15:0] out_d;

   int errors = 0;
   int checks = 0;
   int deliv;
   int done_cnt;
   int grant_log[$];

   // reference model: who owns the path, words still owed, preference, output stage
   int          m_owner;
   int          m_left;
   int          m_ptr;
   bit          m_out_vld;
   logic [15:0] m_out_d;
   bit          m_done;

   buffer_arbiter_16 #(.DW(16), .LW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .len0(len0), .d0(d0), .vld0(vld0),
      .req1(req1), .len1(len1), .d1(d1), .vld1(vld1),
      .gnt0(gnt0), .gnt1(gnt1),
      .out_d(out_d), .out_vld(out_vld), .out_rdy(out_rdy),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_owner   = -1;
      m_left    = 0;
      m_ptr     = 0;
      m_out_vld = 1'b0;
      m_out_d   = 16'h0;
      m_done    = 1'b0;
   endfunction

   // Advance the model by one clock using the inputs about to be sampled
   function automatic void model_step();
      int          o;
      bit          acc;
      bit          v;
      bit          r;
      logic [15:0] d;
      o = m_owner;
      v = (o == 0) ? vld0 : (o == 1) ? vld1 : 1'b0;
      r = (o == 0) ? req0 : (o == 1) ? req1 : 1'b0;
      d = (o == 1) ? d1 : d0;
      acc = (o >= 0) && v && (!m_out_vld || out_rdy);
      if (acc) begin
         m_out_d   = d;
         m_out_vld = 1'b1;
      end else if (out_rdy) begin
         m_out_vld = 1'b0;
      end
      m_done = 1'b0;
      if (o >= 0) begin
         if (acc) m_left = m_left - 1;
         if (acc && m_left == 0) begin
            m_done  = 1'b1;
            m_owner = -1;
            m_ptr   = 1 - o;
         end else if (!r) begin
            m_owner = -1;
            m_ptr   = 1 - o;
         end
      end else if (req0 && (!req1 || m_ptr == 0)) begin
         m_owner = 0;
         m_left  = int'(len0) + 1;
      end else if (req1) begin
         m_owner = 1;
         m_left  = int'(len1) + 1;
      end
   endfunction

   task automatic check_outputs();
      chk("gnt0", 32'(gnt0), 32'(m_owner == 0));
      chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("done", 32'(done), 32'(m_done));
      chk("out_vld", 32'(out_vld), 32'(m_out_vld));
      if (m_out_vld) chk("out_d", 32'(out_d), 32'(m_out_d));
   endtask

   // One clock: drive inputs at negedge, step model, check at the next negedge
   task automatic cyc(input logic r0, input logic [3:0] l0, input logic v0,
                      input logic r1, input logic [3:0] l1, input logic v1,
                      input logic rdy);
      logic pg0, pg1;
      req0 = r0; len0 = l0; vld0 = v0;
      req1 = r1; len1 = l1; vld1 = v1;
      out_rdy = rdy;
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      model_step();
      if (out_vld && out_rdy) deliv++;
      pg0 = gnt0;
      pg1 = gnt1;
      @(posedge clk);
      @(negedge clk);
      if (gnt0 && !pg0) grant_log.push_back(0);
      if (gnt1 && !pg1) grant_log.push_back(1);
      if (done) done_cnt++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic apply_reset();
      req0 = 1'b0; req1 = 1'b0; vld0 = 1'b0; vld1 = 1'b0; out_rdy = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic clear_counts();
      deliv = 0;
      done_cnt = 0;
      grant_log.delete();
   endtask

   initial begin
      logic r0, r1;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; vld0 = 1'b0; vld1 = 1'b0; out_rdy = 1'b0;
      len0 = 4'd0; len1 = 4'd0; d0 = 16'h0; d1 = 16'h0;
      model_reset();
      clear_counts();
      repeat (2) @(negedge clk);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      rst_n = 1'b1;

      // single 3-word burst on port 0
      clear_counts();
      for (int i = 0; i < 7; i++) cyc(i < 4, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t1_done_count", 32'(done_cnt), 32'd1);
      chk("t1_words", 32'(deliv), 32'd3);
      chk("t1_gnt0_low", 32'(gnt0), 32'd0);

      // simultaneous requests from reset alternate 0,1,0
      apply_reset();
      clear_counts();
      for (int i = 0; i < 9; i++) cyc(1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
      chk("t2_grants", 32'(grant_log.size() >= 3), 32'd1);
      if (grant_log.size() >= 3) begin
         chk("t2_first", 32'(grant_log[0]), 32'd0);
         chk("t2_second", 32'(grant_log[1]), 32'd1);
         chk("t2_third", 32'(grant_log[2]), 32'd0);
      end
      idle(4);

      // port 1 burst of 4 with downstream stalled for 4 cycles after word 1
      clear_counts();
      for (int i = 0; i < 12; i++)
         cyc(1'b0, 4'd0, 1'b0, i < 9, 4'd3, 1'b1, !(i >= 2 && i <= 5));
      chk("t3_words", 32'(deliv), 32'd4);
      chk("t3_done_count", 32'(done_cnt), 32'd1);

      // port 1 drops request after 2 of 5 words; port 0 wins the next tie
      clear_counts();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
      chk("t4_abort_idle", 32'(busy), 32'd0);
      cyc(1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
      chk("t4_next_port0", 32'(gnt0), 32'd1);
      chk("t4_no_done", 32'(done_cnt), 32'd0);
      cyc(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      idle(3);

      // maximum-length burst on port 0, length inputs scrambled after grant
      clear_counts();
      for (int i = 0; i < 20; i++)
         cyc(i < 17, (i == 0) ? 4'd15 : 4'($urandom), 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5_words", 32'(deliv), 32'd16);
      chk("t5_done_count", 32'(done_cnt), 32'd1);

      // asynchronous reset between edges in the middle of a burst
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_gnt0", 32'(gnt0), 32'd0);
      chk("t6_out_vld", 32'(out_vld), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      model_reset();
      req0 = 1'b0; vld0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // random traffic: requesters hold for their burst, occasionally abort
      for (int i = 0; i < 3000; i++) begin
         r0 = (m_owner == 0) ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 2) == 0);
         r1 = (m_owner == 1) ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 2) == 0);
         cyc(r0, 4'($urandom), $urandom_range(0, 3) != 0,
             r1, 4'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
